// File: rtl/riscv_mem_io_if.sv
// riscv_mem_io_if: core memory port bundle (address, store data, strobe, lane mask, read data)
interface riscv_mem_io_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [3:0]  writemask;
  logic [31:0] ReadData;
  modport master (output Address, WriteData, MemWrite, writemask, input ReadData);
  modport slave  (input Address, WriteData, MemWrite, writemask, output ReadData);
endinterface

// File: rtl/riscv_mem_io.sv
// riscv_mem_io: word RAM plus IO page (UART TX behind a FIFO, status, cycle counter); MEMIO_LEDS_EN adds an LED register at IO 0x3
module riscv_mem_io #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int IO_BIT       = 22
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_mem_io_if.slave        bus,
  output logic                 uart_tx
`ifdef MEMIO_LEDS_EN
  ,
  output logic [7:0]           leds
`endif
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [PW:0]   DEPTH    = (PW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0]   r_mem [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_count;
  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic [31:0]   r_cycle, r_rdata, w_io_rdata, w_leds_rd;
  logic          w_io, w_push, w_pop, w_full, w_empty, w_busy;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_reg;
  logic          w_unused;

  assign w_io     = bus.Address[IO_BIT];
  assign w_idx    = bus.Address[AW+1:2];
  assign w_reg    = bus.Address[3:2];
  assign w_full   = r_count == DEPTH;
  assign w_empty  = r_count == '0;
  assign w_busy   = r_state != S_IDLE;
  assign w_push   = bus.MemWrite && w_io && w_reg == 2'd0 && bus.writemask[0] && !w_full;
  assign w_pop    = r_state == S_IDLE && !w_empty;
  assign w_unused = ^bus.Address;

  assign w_io_rdata = w_reg == 2'd1 ? {27'b0, !w_empty, w_busy, w_empty, w_full, 1'b0} :
                      w_reg == 2'd2 ? r_cycle :
                      w_reg == 2'd3 ? w_leds_rd : '0;

  // RAM byte-lane store; no reset so it can map onto block RAM
  always_ff @(posedge clk)
    if (bus.MemWrite && !w_io)
      for (int n = 0; n < 4; n++)
        if (bus.writemask[n]) r_mem[w_idx][8*n +: 8] <= bus.WriteData[8*n +: 8];

  // registered read; the RAM word is sampled before this edge's store lands
  always_ff @(posedge clk)
    r_rdata <= reset ? '0 : w_io ? w_io_rdata : r_mem[w_idx];

  assign bus.ReadData = r_rdata;

  // free-running cycle counter
  always_ff @(posedge clk)
    r_cycle <= reset ? '0 : r_cycle + 1'b1;

  // TX FIFO: pushes when not full, pops when the UART leaves idle
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= bus.WriteData[7:0];
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= r_wp + PW'(w_push);
      r_rp    <= r_rp + PW'(w_pop);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  // UART next state; the line level is derived from the next state so uart_tx is a clean register
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: if (w_pop) begin
        w_state_nxt = S_START;
        w_baud_nxt  = '0;
        w_shift_nxt = r_fifo[r_rp];
      end
      default: begin
        w_baud_nxt = r_baud == BAUD_MAX ? '0 : r_baud + 1'b1;
        if (r_baud == BAUD_MAX) begin
          if (r_state == S_START) begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end else if (r_state == S_DATA) begin
            w_shift_nxt = r_shift >> 1;
            w_bit_nxt   = r_bit + 1'b1;
            w_state_nxt = r_bit == 3'd7 ? S_STOP : S_DATA;
          end else w_state_nxt = S_IDLE;
        end
      end
    endcase
    w_tx_nxt = w_state_nxt == S_START ? 1'b0 : w_state_nxt == S_DATA ? w_shift_nxt[0] : 1'b1;
  end

  // UART state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  assign uart_tx = r_tx;

`ifdef MEMIO_LEDS_EN
  logic [7:0] r_leds;
  // LED register written through IO slot 3, lane 0
  always_ff @(posedge clk)
    r_leds <= reset ? '0 :
              (bus.MemWrite && w_io && w_reg == 2'd3 && bus.writemask[0]) ? bus.WriteData[7:0] : r_leds;
  assign leds      = r_leds;
  assign w_leds_rd = {24'b0, r_leds};
`else
  assign w_leds_rd = '0;
`endif
endmodule

// File: tb/tb_riscv_mem_io.sv
// tb_riscv_mem_io: directed checks of RAM, IO page, FIFO and UART framing (CLKS_PER_BIT=4, FIFO_DEPTH=4)
module tb_riscv_mem_io;
  localparam logic [31:0] IO = 32'h0040_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_tx;
`ifdef MEMIO_LEDS_EN
  logic [7:0] leds;
`endif
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rx_err = 0;
  logic [7:0] rx_q[$];
  int rx_t[$];

  riscv_mem_io_if bus();

  riscv_mem_io #(.RAM_WORDS(1024), .CLKS_PER_BIT(4), .FIFO_DEPTH(4), .IO_BIT(22)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .uart_tx(uart_tx)
`ifdef MEMIO_LEDS_EN
    ,
    .leds(leds)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // serial line decoder: samples mid-bit, records byte and start cycle
  initial begin : mon
    logic [7:0] b;
    int t;
    forever begin
      @(posedge clk); #1;
      if (uart_tx === 1'b0) begin
        t = cyc;
        repeat (2) begin @(posedge clk); #1; end
        if (uart_tx !== 1'b0) rx_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (4) begin @(posedge clk); #1; end
          b[i] = uart_tx;
        end
        repeat (4) begin @(posedge clk); #1; end
        if (uart_tx !== 1'b1) rx_err++;
        rx_q.push_back(b);
        rx_t.push_back(t);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.Address = a; bus.WriteData = d; bus.writemask = m; bus.MemWrite = 1'b1;
    tick();
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.Address = a; bus.MemWrite = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.Address = IO | 32'h8;
    tick(3);
    n_chk++; if (bus.ReadData !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", bus.ReadData); else n_pass++;
    n_chk++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else n_pass++;
    reset = 1'b0;
    tick();
    n_chk++; if (bus.ReadData !== 32'h0) $display("FAIL cycle_first: got %h want 00000000", bus.ReadData); else n_pass++;
    tick();
    n_chk++; if (bus.ReadData !== 32'h1) $display("FAIL cycle_second: got %h want 00000001", bus.ReadData); else n_pass++;
    rd(IO | 32'h4);
    n_chk++; if (bus.ReadData !== 32'h4) $display("FAIL reset_stat: got %h want 00000004", bus.ReadData); else n_pass++;
  endtask

  task automatic test_cycle;
    logic [31:0] v1;
    rd(IO | 32'h8);
    v1 = bus.ReadData;
    tick(10);
    n_chk++; if (bus.ReadData - v1 !== 32'd10) $display("FAIL cycle_delta: got %0d want 10", bus.ReadData - v1); else n_pass++;
  endtask

  task automatic test_ram_word;
    wr(32'h10, 32'hDEADBEEF, 4'b1111);
    rd(32'h10);
    n_chk++; if (bus.ReadData !== 32'hDEADBEEF) $display("FAIL ram_word: got %h want deadbeef", bus.ReadData); else n_pass++;
  endtask

  task automatic test_byte_lanes;
    wr(32'h10, 32'h11223344, 4'b1111);
    wr(32'h12, 32'hAAAAAAAA, 4'b0100);
    rd(32'h10);
    n_chk++; if (bus.ReadData !== 32'h11AA3344) $display("FAIL lane2: got %h want 11aa3344", bus.ReadData); else n_pass++;
    wr(32'h10, 32'h55555555, 4'b1001);
    rd(32'h10);
    n_chk++; if (bus.ReadData !== 32'h55AA3355) $display("FAIL lane30: got %h want 55aa3355", bus.ReadData); else n_pass++;
    wr(32'h13, 32'h0, 4'b0000);
    rd(32'h10);
    n_chk++; if (bus.ReadData !== 32'h55AA3355) $display("FAIL mask0: got %h want 55aa3355", bus.ReadData); else n_pass++;
  endtask

  task automatic test_rbw;
    wr(32'h20, 32'h7, 4'b1111);
    bus.Address = 32'h20; bus.WriteData = 32'h5; bus.writemask = 4'b1111; bus.MemWrite = 1'b1;
    tick();
    bus.MemWrite = 1'b0;
    n_chk++; if (bus.ReadData !== 32'h7) $display("FAIL rbw_old: got %h want 00000007", bus.ReadData); else n_pass++;
    tick();
    n_chk++; if (bus.ReadData !== 32'h5) $display("FAIL rbw_new: got %h want 00000005", bus.ReadData); else n_pass++;
  endtask

  task automatic test_wrap;
    rd(32'h1010);
    n_chk++; if (bus.ReadData !== 32'h55AA3355) $display("FAIL wrap_rd: got %h want 55aa3355", bus.ReadData); else n_pass++;
    wr(32'h2020, 32'hCAFEF00D, 4'b1111);
    rd(32'h20);
    n_chk++; if (bus.ReadData !== 32'hCAFEF00D) $display("FAIL wrap_wr: got %h want cafef00d", bus.ReadData); else n_pass++;
  endtask

  task automatic test_io_isolation;
    logic [31:0] e3;
`ifdef MEMIO_LEDS_EN
    e3 = 32'hFF;
`else
    e3 = 32'h0;
`endif
    wr(32'h1C, 32'h12345678, 4'b1111);
    wr(IO | 32'h1C, 32'hFFFFFFFF, 4'b1111);
    rd(32'h1C);
    n_chk++; if (bus.ReadData !== 32'h12345678) $display("FAIL io_no_ram: got %h want 12345678", bus.ReadData); else n_pass++;
    rd(IO | 32'h1C);
    n_chk++; if (bus.ReadData !== e3) $display("FAIL io_slot3: got %h want %h", bus.ReadData, e3); else n_pass++;
    rd(IO);
    n_chk++; if (bus.ReadData !== 32'h0) $display("FAIL io_data_rd: got %h want 00000000", bus.ReadData); else n_pass++;
  endtask

  task automatic test_uart_frame;
    logic [7:0] d;
    logic e;
    d = 8'h55;
    rx_q.delete(); rx_t.delete();
    wr(IO, 32'h55555555, 4'b0001);
    bus.Address = IO | 32'h4;
    n_chk++; if (uart_tx !== 1'b1) $display("FAIL tx_pre: got %b want 1", uart_tx); else n_pass++;
    for (int k = 0; k < 40; k++) begin
      tick();
      e = k < 4 ? 1'b0 : k < 36 ? d[(k-4)/4] : 1'b1;
      n_chk++; if (uart_tx !== e) $display("FAIL tx_k%0d: got %b want %b", k, uart_tx, e); else n_pass++;
      if (k == 20) begin
        n_chk++; if (bus.ReadData[3] !== 1'b1) $display("FAIL stat_busy: got %b want 1", bus.ReadData[3]); else n_pass++;
      end
    end
    tick(3);
    n_chk++; if (bus.ReadData !== 32'h4) $display("FAIL stat_idle: got %h want 00000004", bus.ReadData); else n_pass++;
    n_chk++; if (rx_q.size() !== 1) $display("FAIL rx_count1: got %0d want 1", rx_q.size()); else n_pass++;
    if (rx_q.size() > 0) begin
      n_chk++; if (rx_q[0] !== 8'h55) $display("FAIL rx_55: got %h want 55", rx_q[0]); else n_pass++;
    end
  endtask

  task automatic test_fifo_overflow;
    logic [7:0] e;
    rx_q.delete(); rx_t.delete();
    bus.Address = IO; bus.writemask = 4'b0001; bus.MemWrite = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = 8'(8'hA0 + i);
      bus.WriteData = {4{e}};
      tick();
    end
    bus.MemWrite = 1'b0;
    rd(IO | 32'h4);
    n_chk++; if (bus.ReadData !== 32'h1A) $display("FAIL stat_full: got %h want 0000001a", bus.ReadData); else n_pass++;
    tick(265);
    n_chk++; if (bus.ReadData !== 32'h4) $display("FAIL stat_drained: got %h want 00000004", bus.ReadData); else n_pass++;
    n_chk++; if (rx_q.size() !== 5) $display("FAIL rx_count5: got %0d want 5", rx_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      e = 8'(8'hA0 + i);
      n_chk++; if (rx_q[i] !== e) $display("FAIL rx_byte%0d: got %h want %h", i, rx_q[i], e); else n_pass++;
      if (i > 0) begin
        n_chk++; if (rx_t[i] - rx_t[i-1] !== 41) $display("FAIL frame_gap%0d: got %0d want 41", i, rx_t[i] - rx_t[i-1]); else n_pass++;
      end
    end
    n_chk++; if (rx_err !== 0) $display("FAIL rx_framing: got %0d errors want 0", rx_err); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int lows;
    lows = 0;
    bus.Address = IO; bus.writemask = 4'b0001; bus.MemWrite = 1'b1;
    bus.WriteData = 32'h0;
    tick();
    bus.WriteData = 32'h0F0F0F0F;
    tick();
    bus.MemWrite = 1'b0;
    tick(10);
    n_chk++; if (uart_tx !== 1'b0) $display("FAIL midframe_low: got %b want 0", uart_tx); else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++; if (uart_tx !== 1'b1) $display("FAIL reset_mid_tx: got %b want 1", uart_tx); else n_pass++;
    tick();
    reset = 1'b0;
    rd(IO | 32'h4);
    n_chk++; if (bus.ReadData !== 32'h4) $display("FAIL reset_mid_stat: got %h want 00000004", bus.ReadData); else n_pass++;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    n_chk++; if (lows !== 0) $display("FAIL fifo_discard: got %0d low cycles want 0", lows); else n_pass++;
  endtask

  initial begin
    bus.Address = '0; bus.WriteData = '0; bus.MemWrite = 1'b0; bus.writemask = '0;
    test_reset;
    test_cycle;
    test_ram_word;
    test_byte_lanes;
    test_rbw;
    test_wrap;
    test_io_isolation;
    test_uart_frame;
    test_fifo_overflow;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
